dmem_dump_ctrl: RTL and testbench

Arbiter and sequencer for the data-memory port shared between the pipeline MEM stage and a UART memory-dump engine. The pipeline always owns the port when it issues a read or write. In idle cycles the block fetches consecutive words from a programmed base address and streams them, MSB byte first, to a byte-wide UART transmitter through a valid/ready handshake. It sits between the MEM stage and the data memory, replacing the direct UART hookup to memory.

---
 rtl/dmem_dump_ctrl_pkg.sv | 21 ++
 rtl/dmem_dump_ctrl_word_byte_ser.sv | 70 +++++++
 rtl/dmem_dump_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_dump_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dump_ctrl_pkg.sv
// Shared constants and state encoding for the data-memory dump controller.
// DMEM_DUMP_CHECKSUM_EN adds the CSUM state that sends a trailing XOR byte.
package dmem_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_STRIDE    = 4;
    localparam int CSUM_W         = 8;
    localparam int BYTE_CNT_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_DONE  = 3'd3
`ifdef DMEM_DUMP_CHECKSUM_EN
        ,
        ST_CSUM  = 3'd4
`endif
    } dump_state_t;

endpackage

// File: rtl/dmem_dump_ctrl_word_byte_ser.sv
// Word-to-byte serializer: loads a 32-bit word (or one checksum byte when
// DMEM_DUMP_CHECKSUM_EN is defined) and shifts it out MSB byte first.
module word_byte_ser
    import dmem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_word,
    input  logic [31:0]         word_in,
`ifdef DMEM_DUMP_CHECKSUM_EN
    input  logic                ld_byte,
    input  logic [CSUM_W-1:0]   byte_in,
`endif
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                last_byte_accepted
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]           shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  accept;

    // Handshake: a byte transfers in any cycle where tx_valid && tx_ready;
    // tx_valid and tx_data stay frozen until that happens.
    assign accept             = valid_q & tx_ready;
    assign last_byte_accepted = accept && (cnt_q == LAST_IDX);
    assign tx_data            = shift_q[31:24];
    assign tx_valid           = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (ld_word) begin
            shift_d = word_in;
            cnt_d   = '0;
            valid_d = 1'b1;
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        // A lone checksum byte starts at the last slot so one handshake ends it.
        else if (ld_byte) begin
            shift_d = {byte_in, {(32 - CSUM_W){1'b0}}};
            cnt_d   = LAST_IDX;
            valid_d = 1'b1;
        end
`endif
        else if (accept) begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q + 1'b1;
            valid_d = (cnt_q != LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory port arbiter plus UART dump sequencer; the pipeline always wins.
// DMEM_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last word.
module dmem_dump_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_rd_en,
    input  logic             pipe_wr_en,
    input  logic [31:0]      pipe_addr,
    input  logic [31:0]      pipe_wdata,
    output logic [31:0]      pipe_rdata,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             dump_start,
    input  logic [31:0]      dump_base,
    input  logic [LEN_W-1:0] dump_len,
    output logic             dump_busy,
    output logic             dump_done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    dump_state_t      state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pipe_req;
    logic             fetch_go;
    logic             last_acc;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic              ld_byte;
    logic              accept;

    assign accept  = tx_valid & tx_ready;
    assign ld_byte = (state_q == ST_CSUM) && !tx_valid;
`endif

    assign pipe_req   = pipe_rd_en | pipe_wr_en;
    assign fetch_go   = (state_q == ST_FETCH) && !pipe_req;
    assign pipe_rdata = mem_rdata;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = pipe_addr;
        mem_wdata = pipe_wdata;
        if (pipe_req) begin
            mem_rd_en = pipe_rd_en;
            mem_wr_en = pipe_wr_en;
        end else if (state_q == ST_FETCH) begin
            mem_rd_en = 1'b1;
            mem_addr  = cur_addr_q;
            mem_wdata = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    cur_addr_d = dump_base;
                    rem_d      = dump_len;
                    busy_d     = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    csum_d     = '0;
                    state_d    = (dump_len == '0) ? ST_CSUM : ST_FETCH;
`else
                    state_d    = (dump_len == '0) ? ST_DONE : ST_FETCH;
`endif
                end
            end
            ST_FETCH: begin
                if (!pipe_req) begin
                    cur_addr_d = cur_addr_q + 32'(WORD_STRIDE);
                    rem_d      = rem_q - 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ tx_data;
                end
`endif
                if (last_acc) begin
                    if (rem_q != '0) begin
                        state_d = ST_FETCH;
                    end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (last_acc) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            // Entered with busy still set only from a zero-length start; that
            // path spends one extra cycle here before raising done.
            ST_DONE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    word_byte_ser u_ser (
        .clk                (clk),
        .rst                (rst),
        .ld_word            (fetch_go),
        .word_in            (mem_rdata),
`ifdef DMEM_DUMP_CHECKSUM_EN
        .ld_byte            (ld_byte),
        .byte_in            (csum_q),
`endif
        .tx_ready           (tx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .last_byte_accepted (last_acc)
    );

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Self-checking bench for dmem_dump_ctrl against a byte-stream reference model.
// Honours DMEM_DUMP_CHECKSUM_EN when the design is built with it.
module tb_dmem_dump_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pipe_rd_en = 1'b0;
    logic             pipe_wr_en = 1'b0;
    logic [31:0]      pipe_addr = '0;
    logic [31:0]      pipe_wdata = '0;
    logic [31:0]      pipe_rdata;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             dump_start = 1'b0;
    logic [31:0]      dump_base = '0;
    logic [LEN_W-1:0] dump_len = '0;
    logic             dump_busy;
    logic             dump_done;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;

    dmem_dump_ctrl #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_rd_en (pipe_rd_en),
        .pipe_wr_en (pipe_wr_en),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    // ---------------- clock / cycle counter / memory model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_idx = '0;
    logic [31:0] bk_data = '0;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_data;
        else if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wdata;
    end

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] fetch_q[$];
    int          start_cyc, hs_cyc, first_fetch_cyc, first_valid_cyc;
    int          busy_rise_cyc, done_cnt, done_cyc;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        rdy_rand = 1'b0, pipe_rand = 1'b0;

    // Observe one cycle at the falling edge.
    task automatic sample();
        if (rst === 1'b1 && prev_valid && !prev_ready) begin
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                miscompares++;
                $display("FAIL hold: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, prev_data);
            end
        end
        if (tx_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            got_q.push_back(tx_data);
            hs_cyc = cyc;
        end
        if (pipe_rd_en || pipe_wr_en) begin
            vectors++;
            if (mem_rd_en !== pipe_rd_en || mem_wr_en !== pipe_wr_en || mem_addr !== pipe_addr ||
                pipe_rdata !== mem[pipe_addr[9:2]]) begin
                miscompares++;
                $display("FAIL pipe_mux: rd=%b wr=%b addr=%h rdata=%h, required rd=%b wr=%b addr=%h rdata=%h",
                         mem_rd_en, mem_wr_en, mem_addr, pipe_rdata, pipe_rd_en, pipe_wr_en, pipe_addr,
                         mem[pipe_addr[9:2]]);
            end
        end else if (mem_rd_en === 1'b1) begin
            fetch_q.push_back(mem_addr);
            if (first_fetch_cyc < 0) first_fetch_cyc = cyc;
            vectors++;
            if (mem_wr_en !== 1'b0 || mem_wdata !== 32'h0) begin
                miscompares++;
                $display("FAIL fetch_port: wr=%b wdata=%h, required 0/00000000", mem_wr_en, mem_wdata);
            end
        end
        if (dump_busy === 1'b1 && !prev_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
        if (dump_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            vectors++;
            if (dump_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_at_done: dump_busy=%b, required 0", dump_busy);
            end
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
        prev_busy  = dump_busy;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
        if (pipe_rand) begin
            pipe_rd_en = ($urandom_range(0, 2) == 0);
            pipe_addr  = $urandom;
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        bk_we   = 1'b1;
        bk_idx  = idx;
        bk_data = data;
        tick();
        bk_we   = 1'b0;
    endtask

    // Reference: the dump is the words at base, base+4, ... read MSB byte first.
    task automatic build_exp(input logic [31:0] base, input int len);
        logic [31:0] a;
        logic [31:0] w;
`ifdef DMEM_DUMP_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            a = base + 32'(4 * i);
            w = mem[a[9:2]];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
`ifdef DMEM_DUMP_CHECKSUM_EN
                cs = cs ^ w[8*b +: 8];
`endif
            end
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic start_dump(input logic [31:0] base, input int len);
        got_q.delete();
        fetch_q.delete();
        hs_cyc          = -1;
        first_fetch_cyc = -1;
        first_valid_cyc = -1;
        busy_rise_cyc   = -1;
        done_cnt        = 0;
        done_cyc        = -1;
        build_exp(base, len);
        dump_start = 1'b1;
        dump_base  = base;
        dump_len   = LEN_W'(len);
        start_cyc  = cyc;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic finish_dump(input string name);
        int n;
        int exp_done;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            tick();
            n++;
        end
        vectors++;
        if (done_cnt == 0) begin
            miscompares++;
            $display("FAIL %s_timeout: no dump_done in %0d cycles, required one pulse", name, n);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_count: %0d bytes sent, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        if (done_cnt != 0) begin
            exp_done = (exp_q.size() == 0) ? start_cyc + 2 : hs_cyc + 1;
            vectors++;
            if (done_cyc != exp_done) begin
                miscompares++;
                $display("FAIL %s_done_time: cycle %0d, required %0d", name, done_cyc, exp_done);
            end
        end
        vectors++;
        if (busy_rise_cyc != start_cyc + 1) begin
            miscompares++;
            $display("FAIL %s_busy_rise: cycle %0d, required %0d", name, busy_rise_cyc, start_cyc + 1);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            if (first_valid_cyc >= 0) begin
                miscompares++;
                $display("FAIL %s_no_valid: tx_valid at cycle %0d, required none", name, first_valid_cyc);
            end
        end else if (first_valid_cyc < start_cyc + 2) begin
            miscompares++;
            $display("FAIL %s_first_valid: cycle %0d, required >= %0d", name, first_valid_cyc, start_cyc + 2);
        end
        tick();
        tick();
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s_done_count: %0d pulses, required 1", name, done_cnt);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 256; i++) begin
            bk_we   = 1'b1;
            bk_idx  = 8'(i);
            bk_data = $urandom;
            tick();
        end
        bk_we = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b, required 0/00/0/0",
                     tx_valid, tx_data, dump_busy, dump_done);
        end
        vectors++;
        if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_en: rd=%b wr=%b, required 0/0", mem_rd_en, mem_wr_en);
        end
        pipe_rd_en = 1'b1;
        pipe_addr  = 32'h0000_0044;
        #1;
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 32'h44 || pipe_rdata !== mem[17]) begin
            miscompares++;
            $display("FAIL reset_passthru: rd=%b addr=%h rdata=%h, required 1/00000044/%h",
                     mem_rd_en, mem_addr, pipe_rdata, mem[17]);
        end
        pipe_rd_en = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        logic [7:0] ref_b [5];
        int         nb;
        ref_b[0] = 8'hDE; ref_b[1] = 8'hAD; ref_b[2] = 8'hBE; ref_b[3] = 8'hEF; ref_b[4] = 8'h22;
`ifdef DMEM_DUMP_CHECKSUM_EN
        nb = 5;
`else
        nb = 4;
`endif
        tx_ready = 1'b1;
        poke(8'h04, 32'hDEAD_BEEF);
        start_dump(32'h0000_0010, 1);
        finish_dump("single");
        vectors++;
        if (got_q.size() != nb) begin
            miscompares++;
            $display("FAIL single_handshakes: %0d, required %0d", got_q.size(), nb);
        end
        for (int i = 0; i < nb && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== ref_b[i]) begin
                miscompares++;
                $display("FAIL single_const%0d: got %h, required %h", i, got_q[i], ref_b[i]);
            end
        end
    endtask

    task automatic test_contention();
        tx_ready = 1'b1;
        start_dump(32'h0000_0040, 2);
        pipe_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pipe_addr = $urandom;
            tick();
        end
        pipe_rd_en = 1'b0;
        finish_dump("contention");
        vectors++;
        if (first_fetch_cyc != start_cyc + 6) begin
            miscompares++;
            $display("FAIL contention_fetch: cycle %0d, required %0d", first_fetch_cyc, start_cyc + 6);
        end
    endtask

    task automatic test_backpressure();
        int n;
        tx_ready = 1'b1;
        start_dump(32'h0000_0080, 2);
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        tx_ready = 1'b0;
        repeat (3) tick();
        tx_ready = 1'b1;
        finish_dump("backpressure");
    endtask

    task automatic test_zero_len_wrap();
        tx_ready = 1'b1;
        start_dump(32'h0000_0100, 0);
        finish_dump("zero_len");
        start_dump(32'hFFFF_FFFC, 2);
        finish_dump("wrap");
        vectors++;
        if (fetch_q.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_fetches: %0d fetches, required 2", fetch_q.size());
        end else begin
            vectors++;
            if (fetch_q[0] !== 32'hFFFF_FFFC || fetch_q[1] !== 32'h0000_0000) begin
                miscompares++;
                $display("FAIL wrap_addr: %h then %h, required fffffffc then 00000000", fetch_q[0], fetch_q[1]);
            end
        end
    endtask

    task automatic test_write_through();
        tx_ready = 1'b1;
        start_dump(32'h0000_0300, 3);
        pipe_wr_en = 1'b1;
        pipe_addr  = 32'h0000_0308;
        pipe_wdata = $urandom;
        tick();
        pipe_wr_en = 1'b0;
        build_exp(32'h0000_0300, 3);
        finish_dump("write_through");
    endtask

    task automatic test_reset_restart();
        int n;
        tx_ready = 1'b1;
        start_dump(32'h0000_0200, 2);
        tick();
        dump_start = 1'b1;
        dump_base  = 32'h0000_0280;
        dump_len   = LEN_W'(5);
        tick();
        dump_start = 1'b0;
        finish_dump("ignored_start");

        start_dump(32'h0000_0020, 4);
        n = 0;
        while (got_q.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (got_q.size() < 5) begin
            miscompares++;
            $display("FAIL abort_progress: %0d bytes, required 5", got_q.size());
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: valid=%b busy=%b done=%b, required 0/0/0", tx_valid, dump_busy, dump_done);
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_done: %0d pulses, required 0", done_cnt);
        end
        start_dump(32'h0000_0020, 3);
        finish_dump("restart");
    endtask

    task automatic test_random();
        logic [31:0] base;
        int          len;
        rdy_rand  = 1'b1;
        pipe_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            base = $urandom & 32'hFFFF_FFFC;
            len  = $urandom_range(1, 6);
            start_dump(base, len);
            finish_dump("random");
        end
        rdy_rand   = 1'b0;
        pipe_rand  = 1'b0;
        pipe_rd_en = 1'b0;
        tx_ready   = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_contention();
        test_backpressure();
        test_zero_len_wrap();
        test_write_through();
        test_reset_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
